// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a received XNOR-feedback LFSR stream and reports
// mismatches once locked.
// Optional feature: define LFSR_CHECKER_LOCKUP_DETECT_EN to enable the
// sticky all-ones (XNOR lockup) detector on o_Lockup. When it is defined,
// an all-ones word is also refused as a match while acquiring lock.
// Handshake: a word on i_Data is consumed on every rising edge where
// i_Data_DV is high; there is no back-pressure and idle cycles change nothing.
module lfsr_checker #(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [15:0]         o_Err_Count,
  output logic                o_Lockup,
  output logic [1:0]          o_State
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

`ifdef LFSR_CHECKER_LOCKUP_DETECT_EN
  localparam bit LOCKUP_EN = 1'b1;
`else
  localparam bit LOCKUP_EN = 1'b0;
`endif

  // Feedback taps as a bit mask (bit k-1 set for 1-indexed tap k).
  function automatic logic [7:0] tap_mask(input int n);
    case (n)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      default: return 8'b1011_1000;
    endcase
  endfunction

  localparam logic [7:0]          TAP_MASK8 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK  = TAP_MASK8[NUM_BITS-1:0];
  localparam logic [3:0]          LOCK_CNT  = LOCK_COUNT[3:0];
  localparam logic [3:0]          ERR_LIM   = ERR_LIMIT[3:0];

  // One LFSR step: shift left, feedback is the XNOR of the tap bits.
  function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] r);
    return {r[NUM_BITS-2:0], ~^(r & TAP_MASK)};
  endfunction

  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] r_Pred, pred_nxt;
  logic [3:0]          match_cnt, match_nxt;
  logic [3:0]          err_run, err_run_nxt;
  logic                r_error, error_nxt;
  logic [15:0]         r_err_count;
  logic                r_lockup;
  logic                data_match;
  logic                all_ones;
  logic                verify_match;

  assign data_match   = (i_Data == r_Pred);
  assign all_ones     = &i_Data;
  assign verify_match = data_match && !(LOCKUP_EN && all_ones);

  // Next-state and datapath decisions; only a qualified word advances anything.
  always_comb begin
    state_nxt   = state;
    pred_nxt    = r_Pred;
    match_nxt   = match_cnt;
    err_run_nxt = err_run;
    error_nxt   = 1'b0;
    if (i_Data_DV) begin
      case (state)
        SEARCH: begin
          pred_nxt  = lfsr_next(i_Data);
          match_nxt = 4'd0;
          state_nxt = VERIFY;
        end
        VERIFY: begin
          // Track the received stream while acquiring, match or not.
          pred_nxt = lfsr_next(i_Data);
          if (verify_match) begin
            match_nxt = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_CNT) begin
              state_nxt   = LOCKED;
              err_run_nxt = 4'd0;
            end
          end else begin
            match_nxt = 4'd0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so a bad word cannot derail it.
          pred_nxt = lfsr_next(r_Pred);
          if (data_match) begin
            err_run_nxt = 4'd0;
          end else begin
            error_nxt   = 1'b1;
            err_run_nxt = err_run + 4'd1;
            if (err_run + 4'd1 == ERR_LIM) begin
              state_nxt   = SEARCH;
              err_run_nxt = 4'd0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= SEARCH;
      r_Pred    <= '0;
      match_cnt <= 4'd0;
      err_run   <= 4'd0;
      r_error   <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_Pred    <= pred_nxt;
      match_cnt <= match_nxt;
      err_run   <= err_run_nxt;
      r_error   <= error_nxt;
    end
  end

  // Saturating error counter; a clear overrides a same-cycle error.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_err_count <= 16'd0;
    end else if (i_Clear_Count) begin
      r_err_count <= 16'd0;
    end else if (error_nxt && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

`ifdef LFSR_CHECKER_LOCKUP_DETECT_EN
  // Sticky flag for an all-ones word; only reset clears it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_lockup <= 1'b0;
    end else if (i_Data_DV && all_ones) begin
      r_lockup <= 1'b1;
    end
  end
`else
  assign r_lockup = 1'b0;
`endif

  assign o_Locked    = (state == LOCKED);
  assign o_Error     = r_error;
  assign o_Err_Count = r_err_count;
  assign o_Lockup    = r_lockup;
  assign o_State     = state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker at NUM_BITS=4, LOCK_COUNT=4, ERR_LIMIT=3.
// Expected outputs come from a word-level model that steps the sequence
// through a table of the maximal-length stream rather than tap arithmetic.
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_LOCKUP_DETECT_EN
  localparam bit LOCKUP_EN = 1'b1;
`else
  localparam bit LOCKUP_EN = 1'b0;
`endif
  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 3;
  localparam logic [3:0] SEQ [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                                      4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

  logic        i_Clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_Data_DV = 1'b0;
  logic [3:0]  i_Data = 4'h0;
  logic        i_Clear_Count = 1'b0;
  logic        o_Locked, o_Error, o_Lockup;
  logic [15:0] o_Err_Count;
  logic [1:0]  o_State;

  int checks = 0;
  int failures = 0;

  // Model state
  int          m_mode;     // 0 search, 1 verify, 2 locked
  logic [3:0]  m_pred;
  int          m_match, m_consec;
  logic        m_locked, m_error, m_lockup;
  logic [15:0] m_count;
  logic [3:0]  tx;         // transmitter's current word

  lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Data_DV(i_Data_DV), .i_Data(i_Data),
    .i_Clear_Count(i_Clear_Count), .o_Locked(o_Locked), .o_Error(o_Error),
    .o_Err_Count(o_Err_Count), .o_Lockup(o_Lockup), .o_State(o_State)
  );

  // Clock
  always #5 i_Clk = ~i_Clk;

  function automatic logic [3:0] seq_next(input logic [3:0] x);
    for (int i = 0; i < 15; i++) if (SEQ[i] == x) return SEQ[(i + 1) % 15];
    return 4'hF;  // all-ones maps to itself under XNOR feedback
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_pred = 4'h0; m_match = 0; m_consec = 0;
    m_locked = 1'b0; m_error = 1'b0; m_lockup = 1'b0; m_count = 16'd0;
  endfunction

  function automatic void model_step(input logic dv, input logic [3:0] d, input logic clr);
    logic ones;
    m_error = 1'b0;
    if (dv) begin
      ones = LOCKUP_EN && (d == 4'hF);
      if (ones) m_lockup = 1'b1;
      if (m_mode == 0) begin
        m_pred = seq_next(d); m_match = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == m_pred && !ones) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin m_mode = 2; m_consec = 0; end
        end else m_match = 0;
        m_pred = seq_next(d);
      end else begin
        if (d != m_pred) begin
          m_error = 1'b1; m_consec++;
          if (m_consec == ERR_LIMIT) begin m_mode = 0; m_consec = 0; end
        end else m_consec = 0;
        m_pred = seq_next(m_pred);
      end
    end
    if (clr) m_count = 16'd0;
    else if (m_error && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    m_locked = (m_mode == 2);
  endfunction

  // Driver: present one cycle of inputs, advance the model, sample after the edge.
  task automatic drive(input logic dv, input logic [3:0] d, input logic clr);
    @(negedge i_Clk);
    i_Data_DV = dv; i_Data = d; i_Clear_Count = clr;
    model_step(dv, d, clr);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic send_clean();
    drive(1'b1, tx, 1'b0);
    tx = seq_next(tx);
  endtask

  task automatic apply_reset();
    @(negedge i_Clk);
    i_Rst_L = 1'b0; i_Data_DV = 1'b0; i_Clear_Count = 1'b0;
    model_reset();
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({o_Locked, o_Error, o_Err_Count, o_Lockup, o_State} !== 21'd0) begin
      failures++;
      $display("FAIL reset got lk=%b er=%b cnt=%0d lu=%b st=%0d exp all zero",
               o_Locked, o_Error, o_Err_Count, o_Lockup, o_State);
    end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
  endtask

  task automatic test_acquire();
    tx = 4'h0;
    for (int n = 0; n < 40; n++) begin
      send_clean();
      checks++;
      if ({o_Locked, o_Error, o_Err_Count, o_Lockup} !== {m_locked, m_error, m_count, m_lockup}) begin
        failures++;
        $display("FAIL acquire word=%0d got lk=%b er=%b cnt=%0d lu=%b exp lk=%b er=%b cnt=%0d lu=%b",
                 n, o_Locked, o_Error, o_Err_Count, o_Lockup, m_locked, m_error, m_count, m_lockup);
      end
      if (n == 3 || n == 4) begin
        checks++;
        if (o_Locked !== (n == 4)) begin
          failures++;
          $display("FAIL lock_latency word=%0d got lk=%b exp %b", n, o_Locked, (n == 4));
        end
      end
    end
  endtask

  task automatic test_single_error();
    for (int n = 0; n < 15 && tx != 4'hD; n++) send_clean();
    drive(1'b1, 4'hF, 1'b0);  // replaces 1101
    tx = seq_next(tx);
    checks++;
    if ({o_Locked, o_Error, o_Err_Count} !== {1'b1, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL single_error got lk=%b er=%b cnt=%0d exp lk=1 er=1 cnt=1",
               o_Locked, o_Error, o_Err_Count);
    end
    send_clean();  // 1011 must match
    checks++;
    if ({o_Locked, o_Error, o_Err_Count, o_Lockup} !== {1'b1, 1'b0, 16'd1, m_lockup} || tx != 4'h6) begin
      failures++;
      $display("FAIL after_error got lk=%b er=%b cnt=%0d lu=%b exp lk=1 er=0 cnt=1 lu=%b",
               o_Locked, o_Error, o_Err_Count, o_Lockup, m_lockup);
    end
  endtask

  task automatic test_clear_with_error();
    drive(1'b1, tx ^ 4'h4, 1'b1);
    tx = seq_next(tx);
    checks++;
    if ({o_Error, o_Err_Count} !== {1'b1, 16'd0} || m_count != 16'd0) begin
      failures++;
      $display("FAIL clear_wins got er=%b cnt=%0d exp er=1 cnt=0", o_Error, o_Err_Count);
    end
    for (int n = 0; n < 3; n++) send_clean();
  endtask

  task automatic test_burst();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, tx ^ 4'($urandom_range(1, 15)), 1'b0);
      tx = seq_next(tx);
      checks++;
      if ({o_Locked, o_Error, o_Err_Count} !== {(n < 2), 1'b1, m_count}) begin
        failures++;
        $display("FAIL burst n=%0d got lk=%b er=%b cnt=%0d exp lk=%b er=1 cnt=%0d",
                 n, o_Locked, o_Error, o_Err_Count, (n < 2), m_count);
      end
    end
    for (int n = 0; n < 5; n++) begin
      send_clean();
      checks++;
      if ({o_Locked, o_Error, o_Err_Count} !== {(n == 4), 1'b0, m_count} || m_locked != (n == 4)) begin
        failures++;
        $display("FAIL relock n=%0d got lk=%b er=%b cnt=%0d exp lk=%b er=0 cnt=%0d",
                 n, o_Locked, o_Error, o_Err_Count, (n == 4), m_count);
      end
    end
  endtask

  task automatic test_alternating_dv();
    apply_reset();
    tx = 4'($urandom_range(0, 14));
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) send_clean();
      else drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      checks++;
      if ({o_Locked, o_Error, o_Err_Count, o_Lockup} !== {m_locked, m_error, m_count, m_lockup}) begin
        failures++;
        $display("FAIL alt_dv cyc=%0d got lk=%b er=%b cnt=%0d lu=%b exp lk=%b er=%b cnt=%0d lu=%b",
                 n, o_Locked, o_Error, o_Err_Count, o_Lockup, m_locked, m_error, m_count, m_lockup);
      end
    end
    checks++;
    if (o_Locked !== 1'b1) begin
      failures++;
      $display("FAIL alt_dv_lock got lk=%b exp 1", o_Locked);
    end
  endtask

  task automatic test_reset_midlock();
    drive(1'b1, tx ^ 4'h1, 1'b0);  // leave a nonzero count
    tx = seq_next(tx);
    @(posedge i_Clk);
    #3 i_Rst_L = 1'b0;
    #1;
    checks++;
    if ({o_Locked, o_Error, o_Err_Count, o_Lockup} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset got lk=%b er=%b cnt=%0d lu=%b exp all zero",
               o_Locked, o_Error, o_Err_Count, o_Lockup);
    end
    model_reset();
    i_Data_DV = 1'b0;
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    for (int n = 0; n < 6; n++) begin
      send_clean();
      checks++;
      if ({o_Locked, o_Error, o_Err_Count} !== {m_locked, m_error, m_count} || m_locked != (n >= 4)) begin
        failures++;
        $display("FAIL reacquire n=%0d got lk=%b er=%b cnt=%0d exp lk=%b er=%b cnt=%0d",
                 n, o_Locked, o_Error, o_Err_Count, m_locked, m_error, m_count);
      end
    end
  endtask

  task automatic test_random();
    logic       dv, clr;
    logic [3:0] d;
    for (int n = 0; n < 400; n++) begin
      dv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if (!dv) d = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) d = tx ^ 4'($urandom_range(1, 15));
      else d = tx;
      drive(dv, d, clr);
      if (dv) tx = seq_next(tx);
      checks++;
      if ({o_Locked, o_Error, o_Err_Count, o_Lockup} !== {m_locked, m_error, m_count, m_lockup}) begin
        failures++;
        $display("FAIL random cyc=%0d got lk=%b er=%b cnt=%0d lu=%b exp lk=%b er=%b cnt=%0d lu=%b",
                 n, o_Locked, o_Error, o_Err_Count, o_Lockup, m_locked, m_error, m_count, m_lockup);
      end
    end
  endtask

  task automatic test_lockup();
    apply_reset();
    drive(1'b1, 4'hF, 1'b0);
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 4'($urandom_range(0, 14)), 1'b0);
      checks++;
      if (o_Lockup !== LOCKUP_EN || o_Locked !== m_locked) begin
        failures++;
        $display("FAIL lockup n=%0d got lu=%b lk=%b exp lu=%b lk=%b",
                 n, o_Lockup, o_Locked, LOCKUP_EN, m_locked);
      end
    end
    apply_reset();
    checks++;
    if (o_Lockup !== 1'b0) begin
      failures++;
      $display("FAIL lockup_reset got lu=%b exp 0", o_Lockup);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_single_error();
    test_clear_with_error();
    test_burst();
    test_alternating_dv();
    test_reset_midlock();
    test_random();
    test_lockup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
